sortmax_trace_fifo: RTL and testbench



---
 rtl/sortmax_trace_fifo.sv | 109 ++++++++++
 tb/tb_sortmax_trace_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sortmax_trace_fifo.sv
// sortmax_trace_fifo
//   Logs every change of the upstream sortmax FSM output vector together with a
//   free-running cycle timestamp. The log is a first-word-fall-through FIFO.
//   When the FIFO is full and the consumer does not pop, new captures are dropped.
//   Dropped captures are counted in a saturating 8-bit counter.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   en           capture/timestamp enable
//   y_in         upstream control vector, bit 0 = y1 ... bit 19 = y20
//   out_valid    head entry available
//   out_ready    consumer accepts head
//   out_data     head entry {timestamp, y_vector}
//   fifo_count   current occupancy
//   full         fifo_count == DEPTH
//   overflow_cnt dropped captures, saturating at 255
module sortmax_trace_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TS_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [19:0]              y_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TS_W+19:0]         out_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     full,
   output logic [7:0]               overflow_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = TS_W + 20;

   logic [TS_W-1:0] ts_q, ts_d;
   logic [19:0]     prev_y_q, prev_y_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      ovf_q, ovf_d;
   logic [EW-1:0]   mem [DEPTH];

   logic capture, push, pop, drop;

   always_comb begin
      full      = (count_q == CW'(DEPTH));
      out_valid = (count_q != '0);
      capture   = en && (y_in != prev_y_q);
      pop       = out_valid && out_ready;
      // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
      push      = capture && (!full || pop);
      drop      = capture && full && !pop;
   end

   always_comb begin
      ts_d     = ts_q;
      prev_y_d = prev_y_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (en) begin
         ts_d     = ts_q + TS_W'(1);
         prev_y_d = y_in;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q     <= '0;
         prev_y_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= '0;
      end else begin
         ts_q     <= ts_d;
         prev_y_q <= prev_y_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is not reset; reset gates the write so in-flight captures are discarded.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr_q] <= {ts_q, y_in};
   end

   assign out_data     = mem[rd_ptr_q];
   assign fifo_count   = count_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_sortmax_trace_fifo.sv
module tb_sortmax_trace_fifo;

   logic        clk = 1'b0;
   logic        rst, en, out_ready;
   logic [19:0] y_in;
   logic        out_valid, full;
   logic [35:0] out_data;
   logic [3:0]  fifo_count;
   logic [7:0]  overflow_cnt;

   // Narrow-timestamp instance for the wrap check.
   logic        rst_b, en_b;
   logic [19:0] y_b;
   logic        valid_b, full_b;
   logic [23:0] data_b;
   logic [3:0]  count_b;
   logic [7:0]  ovf_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sortmax_trace_fifo #(.DEPTH(8), .TS_W(16)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .y_in         (y_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .fifo_count   (fifo_count),
      .full         (full),
      .overflow_cnt (overflow_cnt)
   );

   sortmax_trace_fifo #(.DEPTH(8), .TS_W(4)) u_dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .en           (en_b),
      .y_in         (y_b),
      .out_valid    (valid_b),
      .out_ready    (1'b0),
      .out_data     (data_b),
      .fifo_count   (count_b),
      .full         (full_b),
      .overflow_cnt (ovf_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; out_ready = 1'b0; y_in = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; out_ready = 1'b0; y_in = '0;
      rst_b = 1'b1; en_b = 1'b0; y_b = '0;

      // Reset state
      do_reset();
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_full", full, 0);
      check_eq("rst_ovf", overflow_cnt, 0);

      // First capture after reset: nonzero y vs prev_y=0, ts=0, visible next cycle
      en = 1'b1; y_in = 20'h000E0;
      tick();
      check_eq("first_valid", out_valid, 1);
      check_eq("first_data", out_data, {16'h0000, 20'h000E0});
      check_eq("first_count", fifo_count, 1);

      // Head stable while not ready
      en = 1'b0; y_in = 20'h12345;
      tick(); tick();
      check_eq("hold_data", out_data, {16'h0000, 20'h000E0});
      check_eq("hold_valid", out_valid, 1);

      // Pop, then ready on empty has no effect
      out_ready = 1'b1;
      tick();
      check_eq("pop_valid", out_valid, 0);
      check_eq("pop_count", fifo_count, 0);
      tick();
      check_eq("empty_ready_count", fifo_count, 0);

      // Constant zero input: no captures, ts advances to 5
      do_reset();
      en = 1'b1; y_in = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("zero_valid", out_valid, 0);
      end
      y_in = 20'h00001;
      tick();
      check_eq("ts5_data", out_data, {16'd5, 20'h00001});

      // Fill past full: 10 distinct captures, 8 stored, 2 dropped
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         y_in = 20'(i + 1);
         tick();
         check_eq("fill_count", fifo_count, (i < 8) ? i + 1 : 8);
         check_eq("fill_full", full, (i >= 7) ? 1 : 0);
      end
      check_eq("fill_ovf", overflow_cnt, 2);
      check_eq("fill_head", out_data, {16'd0, 20'h00001});

      // Full with simultaneous push and pop: lossless
      out_ready = 1'b1; y_in = 20'h00055;
      tick();
      check_eq("pp_count", fifo_count, 8);
      check_eq("pp_ovf", overflow_cnt, 2);
      check_eq("pp_head", out_data, {16'd1, 20'h00002});

      // Drain and confirm order; new entry landed at the tail with ts=10
      en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k < 7) check_eq("drain_data", out_data, {16'(k + 1), 20'(k + 2)});
         else       check_eq("drain_tail", out_data, {16'd10, 20'h00055});
         tick();
      end
      check_eq("drain_count", fifo_count, 0);

      // en=0: toggling input is ignored, ts held at 11
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         y_in = 20'(i * 7 + 3);
         tick();
         check_eq("dis_count", fifo_count, 0);
      end
      en = 1'b1; y_in = 20'h00055;
      tick();
      check_eq("reen_same", fifo_count, 0);
      y_in = 20'hAAAAA;
      tick();
      check_eq("reen_data", out_data, {16'd12, 20'hAAAAA});

      // Reset mid-operation with count=5, ovf=3; reset beats push/pop
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         y_in = 20'(i + 1);
         tick();
      end
      en = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      check_eq("pre_rst_count", fifo_count, 5);
      check_eq("pre_rst_ovf", overflow_cnt, 3);
      rst = 1'b1; en = 1'b1; y_in = 20'h0F0F0;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_count", fifo_count, 0);
      check_eq("mid_rst_full", full, 0);
      check_eq("mid_rst_ovf", overflow_cnt, 0);
      y_in = 20'h00003;
      tick();
      check_eq("post_rst_data", out_data, {16'd0, 20'h00003});

      // Overflow counter saturates at 255
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 268; i++) begin
         y_in = 20'(i + 1);
         tick();
      end
      check_eq("ovf_sat", overflow_cnt, 255);
      check_eq("ovf_sat_head", out_data, {16'd0, 20'h00001});

      // TS_W=4 wraps: 17 enabled cycles leave ts=1
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0; en_b = 1'b1; y_b = '0;
      for (int i = 0; i < 17; i++) tick();
      check_eq("wrap_empty", valid_b, 0);
      y_b = 20'h00001;
      tick();
      check_eq("wrap_data", data_b, {4'd1, 20'h00001});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
